// File: rtl/img_unpacket.sv
// Reader-side unpacker: pops one stored image packet from a FWFT FIFO, streams the pixel
// words out on valid/ready, and validates the trailer (parity, frame type, reserved bits).
module img_unpacket #(
  parameter int LINE_SIZE  = 1024,
  parameter int IMAGE_SIZE = 1024 * 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fifo_rddata,
  input  logic        fifo_empty,
  output logic        fifo_rden,
  input  logic        frame_start,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  input  logic        data_out_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  frame_type_o,
  output logic        parity_err,
  output logic        pad_err
);

  localparam int WR_NUM  = IMAGE_SIZE / 4;
  localparam int TRL_NUM = LINE_SIZE / 4;
  localparam int CNT_MAX = (WR_NUM > TRL_NUM) ? WR_NUM : TRL_NUM;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_NUM - 1);
  localparam logic [CNT_W-1:0] TRL_LAST  = CNT_W'(TRL_NUM - 1);
  localparam logic [CNT_W-1:0] TYPE_WORD = CNT_W'(4);
  localparam logic [31:0]      TYPE_MASK = 32'h0000_0300;

  // Handshake: a word moves on data_out when data_out_valid && data_out_ready at a rising
  // edge; data_out holds steady while valid is high and ready is low.

  typedef enum logic [1:0] {IDLE, DATA, TRAILER, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              done_fire;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       acc;
  logic              trl_par_bad;
  logic              trl_pad_bad;
  logic [1:0]        trl_type;
  logic [31:0]       rsv_mask;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    fifo_rden = 1'b0;
    done_fire = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_nxt = DATA;
      end
      DATA: begin
        fifo_rden = !fifo_empty && (!data_out_valid || data_out_ready);
        if (fifo_rden && (cnt == WR_LAST)) state_nxt = TRAILER;
      end
      TRAILER: begin
        fifo_rden = !fifo_empty;
        if (fifo_rden && (cnt == TRL_LAST)) state_nxt = DONE;
      end
      DONE: begin
        // Report only once the last pixel has left the output register.
        if (!data_out_valid) begin
          done_fire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // T0 is the parity word; T4 carries the type in [9:8]; every other trailer bit is reserved.
  always_comb begin
    rsv_mask = 32'hFFFF_FFFF;
    if (cnt == '0)            rsv_mask = 32'h0000_0000;
    else if (cnt == TYPE_WORD) rsv_mask = ~TYPE_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
      frame_type_o   <= '0;
      parity_err     <= 1'b0;
      pad_err        <= 1'b0;
      cnt            <= '0;
      acc            <= '0;
      trl_par_bad    <= 1'b0;
      trl_pad_bad    <= 1'b0;
      trl_type       <= '0;
    end else begin
      frame_done <= done_fire;
      if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;

      if (state == IDLE && frame_start) begin
        cnt         <= '0;
        acc         <= '0;
        trl_par_bad <= 1'b0;
        trl_pad_bad <= 1'b0;
        trl_type    <= '0;
      end

      if (fifo_rden && state == DATA) begin
        data_out       <= fifo_rddata;
        data_out_valid <= 1'b1;
        acc            <= acc ^ fifo_rddata;
        cnt            <= (cnt == WR_LAST) ? '0 : cnt + CNT_W'(1);
      end

      if (fifo_rden && state == TRAILER) begin
        if (cnt == '0)        trl_par_bad <= (fifo_rddata != acc);
        if (cnt == TYPE_WORD) trl_type    <= fifo_rddata[9:8];
        if (|(fifo_rddata & rsv_mask)) trl_pad_bad <= 1'b1;
        cnt <= (cnt == TRL_LAST) ? '0 : cnt + CNT_W'(1);
      end

      if (done_fire) begin
        parity_err   <= trl_par_bad;
        pad_err      <= trl_pad_bad;
        frame_type_o <= trl_type;
        acc          <= '0;
        cnt          <= '0;
      end
    end
  end

endmodule
